// File: rtl/march_bist_ctrl.sv
// March C- BIST initiator: drives one single-port RAM over its native bus and reports busy/done/fail.
// Latency: first RAM op the cycle after start is sampled; 10*2^Adr_size op cycles, then done.
// Backpressure: none; start is ignored while busy and the test always runs to completion.
//
// Ports: clk/rst_n (async active-low); start (one-cycle request); adress/data/wr_en/read_en (RAM bus,
// data driven only while wr_en); busy, done (sticky), fail (sticky, any read mismatch).
// Optional macro BIST_DIAG_EN adds fail_adr/fail_exp/fail_act/fail_elem, holding the first mismatch.
module march_bist_ctrl #(
    parameter int Dta_size = 8,
    parameter int Adr_size = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [Adr_size-1:0] adress,
    inout  wire  [Dta_size-1:0] data,
    output logic                wr_en,
    output logic                read_en,
    output logic                busy,
    output logic                done,
    output logic                fail
`ifdef BIST_DIAG_EN
    ,
    output logic [Adr_size-1:0] fail_adr,
    output logic [Dta_size-1:0] fail_exp,
    output logic [Dta_size-1:0] fail_act,
    output logic [2:0]          fail_elem
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [Adr_size-1:0] ADR_MAX = '1;
    localparam logic [Adr_size-1:0] ADR_ONE = Adr_size'(1);

    state_t              state, state_nxt;
    logic [2:0]          elem, elem_nxt;
    logic [Adr_size-1:0] addr_nxt;

    // Elements 0..2 walk up, 3..5 walk down.
    logic                down;
    logic                last;
    logic [Adr_size-1:0] adr_step;
    logic [2:0]          elem_inc;
    logic [Adr_size-1:0] next_start;
    logic                start_ok;
    logic [Dta_size-1:0] wr_bg;
    logic [Dta_size-1:0] rd_exp;
    logic                mismatch;

    assign down       = (elem >= 3'd3);
    assign last       = down ? (adress == '0) : (adress == ADR_MAX);
    assign adr_step   = down ? (adress - ADR_ONE) : (adress + ADR_ONE);
    assign elem_inc   = elem + 3'd1;
    assign next_start = (elem_inc >= 3'd3) ? ADR_MAX : '0;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));

    // Odd elements write ones (w1); reads always expect the complement of the
    // element parity: r0 in 1/3/5, r1 in 2/4.
    assign wr_bg    = {Dta_size{elem[0]}};
    assign rd_exp   = {Dta_size{~elem[0]}};
    assign mismatch = (state == RD) && (data != rd_exp);

    // Bus released in every cycle except registered write cycles.
    assign data = wr_en ? wr_bg : {Dta_size{1'bz}};

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = adress;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WR;
                    elem_nxt  = 3'd0;
                    addr_nxt  = '0;
                end
            end
            RD: begin
                if (elem != 3'd5) begin
                    state_nxt = WR;            // read-then-write at the same address
                end else if (last) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt = adr_step;
                end
            end
            WR: begin
                if (!last) begin
                    addr_nxt  = adr_step;
                    state_nxt = (elem == 3'd0) ? WR : RD;   // elem 0 is write-only
                end else begin
                    elem_nxt  = elem_inc;
                    addr_nxt  = next_start;
                    state_nxt = RD;            // every later element opens with a read
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with adress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            elem    <= 3'd0;
            adress  <= '0;
            wr_en   <= 1'b0;
            read_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state   <= state_nxt;
            elem    <= elem_nxt;
            adress  <= addr_nxt;
            wr_en   <= (state_nxt == WR);
            read_en <= (state_nxt == RD);
            busy    <= (state_nxt == WR) || (state_nxt == RD);
            done    <= (state_nxt == DONE);
            if (start_ok)
                fail <= 1'b0;
            else if (mismatch)
                fail <= 1'b1;
        end
    end

`ifdef BIST_DIAG_EN
    // Captured only while fail is still clear, so the first mismatch sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_adr  <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
        end else if (start_ok) begin
            fail_adr  <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
        end else if (mismatch && !fail) begin
            fail_adr  <= adress;
            fail_exp  <= rd_exp;
            fail_act  <= data;
            fail_elem <= elem;
        end
    end
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl with a behavioural RAM that can inject faults.
// Expected op stream and verdict come from a March C- table walked with plain loops.
module tb_march_bist_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] adress;
    wire  [DW-1:0] data;
    logic          wr_en, read_en, busy, done, fail;
`ifdef BIST_DIAG_EN
    logic [AW-1:0] fail_adr;
    logic [DW-1:0] fail_exp, fail_act;
    logic [2:0]    fail_elem;
`endif

    int ncmp = 0;
    int nbad = 0;

    // Fault configuration shared by the RAM and the reference model.
    logic          stk_en = 1'b0;
    logic [AW-1:0] stk_a  = '0;
    logic [2:0]    stk_b  = '0;
    logic          cpl_en = 1'b0;
    logic [AW-1:0] cpl_a  = '0;
    logic [AW-1:0] cpl_b  = '0;

    // Reference model results.
    op_t           exp_q[$];
    logic [DW-1:0] mm[N];
    logic          exp_fail;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fx, exp_fact;
    logic [2:0]    exp_fe;

    always #5 clk = ~clk;

    march_bist_ctrl #(.Dta_size(DW), .Adr_size(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adress(adress), .data(data),
        .wr_en(wr_en), .read_en(read_en), .busy(busy), .done(done), .fail(fail)
`ifdef BIST_DIAG_EN
        , .fail_adr(fail_adr), .fail_exp(fail_exp), .fail_act(fail_act), .fail_elem(fail_elem)
`endif
    );

    // Behavioural RAM with optional stuck-at-1 bit and write-coupling fault.
    logic [DW-1:0] ram[N];
    logic [DW-1:0] ram_q;
    int            nwr = 0;

    assign ram_q = ram[adress] | ((stk_en && adress == stk_a) ? (8'h01 << stk_b) : 8'h00);
    assign data  = read_en ? ram_q : {DW{1'bz}};

    always @(posedge clk) begin
        if (wr_en) begin
            ram[adress] <= data;
            if (cpl_en && adress == cpl_a)
                ram[cpl_b] <= data;
            nwr <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv)
        else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        ncmp++;
        assert (!(wr_en && read_en))
        else begin
            nbad++;
            $error("FAIL bus_excl observed wr_en=%0b read_en=%0b expected not both", wr_en, read_en);
        end
        if (read_en) begin
            ncmp++;
            assert (data === ram_q)
            else begin
                nbad++;
                $error("FAIL rd_bus observed=%0h expected=%0h", data, ram_q);
            end
        end
    end

    // March C- as a table: per element a read value (-1 none), a write value (-1 none), direction.
    task automatic build_model();
        int rd_v[6] = '{-1, 0, 1, 0, 1, 0};
        int wr_v[6] = '{0, 1, 0, 1, 0, -1};
        int up_e[6] = '{1, 1, 1, 0, 0, 0};
        logic [AW-1:0] a;
        logic [DW-1:0] v, ev;
        exp_q.delete();
        exp_fail = 1'b0; exp_fa = '0; exp_fx = '0; exp_fact = '0; exp_fe = '0;
        for (int i = 0; i < N; i++) mm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = AW'(up_e[e] != 0 ? k : N - 1 - k);
                if (rd_v[e] >= 0) begin
                    v  = mm[a] | ((stk_en && a == stk_a) ? (8'h01 << stk_b) : 8'h00);
                    ev = (rd_v[e] == 1) ? 8'hFF : 8'h00;
                    if (v != ev && !exp_fail) begin
                        exp_fail = 1'b1; exp_fa = a; exp_fx = ev; exp_fact = v; exp_fe = 3'(e);
                    end
                    exp_q.push_back('{we: 1'b0, a: a, d: v});
                end
                if (wr_v[e] >= 0) begin
                    v = (wr_v[e] == 1) ? 8'hFF : 8'h00;
                    mm[a] = v;
                    if (cpl_en && a == cpl_a) mm[cpl_b] = v;
                    exp_q.push_back('{we: 1'b1, a: a, d: v});
                end
            end
        end
    endtask

    // Called at a negedge. abort_at / spur_at < 0 disable reset drop / spurious start.
    task automatic run_test(input int abort_at, input int spur_at);
        int cyc;
        int w0;
        int r0;
        build_model();
        w0 = nwr;
        r0 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_clr", 32'(done), 32'd0);
        chk("fail_clr", 32'(fail), 32'd0);
        cyc = 0;
        while (busy && cyc < 10 * N + 20) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_idle", {wr_en, read_en, busy, done, fail, adress}, 32'd0);
                w0 = nwr;
                repeat (5) @(negedge clk);
                chk("rst_no_wr", nwr, w0);
                chk("rst_hold", {wr_en, read_en, busy, done, fail, adress}, 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            start = (cyc == spur_at);
            if (cyc < exp_q.size())
                chk($sformatf("op%0d", cyc), {wr_en, read_en, adress, data},
                    {exp_q[cyc].we, ~exp_q[cyc].we, exp_q[cyc].a, exp_q[cyc].d});
            else
                chk("op_overrun", cyc, exp_q.size());
            if (read_en) r0++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("busy_cycles", cyc, 10 * N);
        chk("done_end", 32'(done), 32'd1);
        chk("fail_end", 32'(fail), 32'(exp_fail));
        chk("n_writes", nwr - w0, 5 * N);
        chk("n_reads", r0, 5 * N);
`ifdef BIST_DIAG_EN
        chk("diag", {fail_adr, fail_exp, fail_act, fail_elem}, {exp_fa, exp_fx, exp_fact, exp_fe});
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {wr_en, read_en, busy, done, fail}, 32'd0);
        chk("rst_adr", 32'(adress), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ctl", {wr_en, read_en, busy, done, fail}, 32'd0);

        // Fault-free run with an ignored start at op cycle 20.
        run_test(-1, 20);

        // Stuck-at-1 on bit 0 of address 5: first read of elem 1 there sees 0x01.
        stk_en = 1'b1; stk_a = 4'd5; stk_b = 3'd0;
        run_test(-1, -1);
        chk("stuck_fail", 32'(fail), 32'd1);
`ifdef BIST_DIAG_EN
        chk("stuck_diag", {fail_adr, fail_exp, fail_act, fail_elem}, {4'd5, 8'h00, 8'h01, 3'd1});
`endif
        stk_en = 1'b0;

        // Write to 3 also lands on 7.
        cpl_en = 1'b1; cpl_a = 4'd3; cpl_b = 4'd7;
        run_test(-1, -1);
        chk("cpl_fail", 32'(fail), 32'd1);
        cpl_en = 1'b0;

        // Reset dropped mid-test, then a clean full run.
        run_test(40, -1);
        run_test(-1, -1);
        chk("after_rst_fail", 32'(fail), 32'd0);

        // Randomised fault scenarios and spurious start positions.
        for (int t = 0; t < 5; t++) begin
            int kind;
            kind   = $urandom_range(0, 2);
            stk_en = (kind == 1);
            cpl_en = (kind == 2);
            stk_a  = AW'($urandom_range(0, N - 1));
            stk_b  = 3'($urandom_range(0, DW - 1));
            cpl_a  = AW'($urandom_range(0, N - 1));
            cpl_b  = cpl_a + AW'($urandom_range(1, N - 1));
            run_test(-1, $urandom_range(1, 10 * N - 1));
        end
        stk_en = 1'b0;
        cpl_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

endmodule
